// File: rtl/viol_reset_seq.sv
// viol_reset_seq: merges level violation requests into a registered CPU reset with minimum pulse width, sticky cause and episode counter
// Ports: clk, rst_n (async active-low), viol_req[NUM_SRC] level requests, cause_clr clear in idle,
//        reset_out registered CPU reset, busy (== reset_out), cause sticky source OR, viol_cnt saturating episode count.
// Macro VIOL_CAUSE_LOG_EN: when defined, cause/viol_cnt/cause_clr are implemented; otherwise cause and viol_cnt read 0.
module viol_reset_seq #(
  parameter int NUM_SRC     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] viol_req,
  input  logic               cause_clr,
  output logic               reset_out,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic [CNT_W-1:0]   viol_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ASSERT, DRAIN} state_t;
  state_t        r_state, w_state_nxt;
  logic [HW-1:0] r_hold;
  logic          r_reset_out, w_reset_nxt, w_req_any;
  assign w_req_any = |viol_req;
  // hold counter only moves in ASSERT and stops at zero, so it never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_reset_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_reset_out <= w_reset_nxt;
      r_hold      <= (r_state == IDLE && w_req_any) ? HW'(HOLD_CYCLES - 1) :
                     (r_state == ASSERT && r_hold != '0) ? r_hold - HW'(1) : r_hold;
    end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_any) w_state_nxt = ASSERT;
      ASSERT:  if (r_hold == '0) w_state_nxt = w_req_any ? DRAIN : IDLE;
      DRAIN:   if (!w_req_any) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // reset_out is decoded from the next state so it rises the cycle after the request
  always_comb begin
    w_reset_nxt = w_state_nxt != IDLE;
  end
  assign reset_out = r_reset_out;
  assign busy      = r_reset_out;
`ifdef VIOL_CAUSE_LOG_EN
  logic [NUM_SRC-1:0] r_cause;
  logic [CNT_W-1:0]   r_viol_cnt;
  // a new request in IDLE takes priority over cause_clr
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cause    <= '0;
      r_viol_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_req_any) begin
        r_cause    <= viol_req;
        r_viol_cnt <= (r_viol_cnt == '1) ? r_viol_cnt : r_viol_cnt + CNT_W'(1);
      end else if (cause_clr) begin
        r_cause    <= '0;
        r_viol_cnt <= '0;
      end
    end else begin
      r_cause <= r_cause | viol_req;
    end
  assign cause    = r_cause;
  assign viol_cnt = r_viol_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = cause_clr;
  assign cause        = '0;
  assign viol_cnt     = '0;
`endif
endmodule

// File: tb/tb_viol_reset_seq.sv
// tb_viol_reset_seq: randomized and directed checks of viol_reset_seq against an episode-level model
module tb_viol_reset_seq;
  localparam int HOLD = 16;
  localparam int CMAX = 255;
  localparam bit LOG =
`ifdef VIOL_CAUSE_LOG_EN
    1'b1;
`else
    1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] viol_req = '0;
  logic       cause_clr = 1'b0;
  logic       reset_out, busy;
  logic [3:0] cause;
  logic [7:0] viol_cnt;
  int cmps = 0;
  int errs = 0;
  // model: an episode is active from the request until the hold time has elapsed and requests have cleared
  bit         m_active;
  int         m_left;
  logic [3:0] m_cause;
  int         m_cnt;

  viol_reset_seq dut (
    .clk(clk), .rst_n(rst_n), .viol_req(viol_req), .cause_clr(cause_clr),
    .reset_out(reset_out), .busy(busy), .cause(cause), .viol_cnt(viol_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] e_cause();
    return LOG ? m_cause : 4'b0;
  endfunction
  function automatic logic [7:0] e_cnt();
    return LOG ? 8'(m_cnt) : 8'd0;
  endfunction

  task automatic step(input logic [3:0] req, input logic clr);
    viol_req  = req;
    cause_clr = clr;
    @(posedge clk);
    if (!m_active) begin
      if (req != 0) begin
        m_active = 1;
        m_left   = HOLD - 1;
        m_cause  = req;
        m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (clr) begin
        m_cause = 0;
        m_cnt   = 0;
      end
    end else begin
      m_cause |= req;
      if (m_left > 0) m_left--;
      else if (req == 0) m_active = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    viol_req = '0;
    cause_clr = 1'b0;
    m_active = 0; m_left = 0; m_cause = 0; m_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    cmps++;
    if ({reset_out, busy, cause, viol_cnt} !== 14'd0) begin
      errs++;
      $display("FAIL reset: got ro=%b busy=%b cause=%h cnt=%0d exp all 0", reset_out, busy, cause, viol_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 1; c <= 9; c++) step(4'b0, 1'b0);
    step(4'b0001, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      cmps++;
      if (reset_out !== (k <= HOLD) || {busy, cause, viol_cnt} !== {m_active, e_cause(), e_cnt()}) begin
        errs++;
        $display("FAIL single k%0d: got ro=%b busy=%b cause=%h cnt=%0d exp ro=%b cause=%h cnt=%0d",
                 k, reset_out, busy, cause, viol_cnt, k <= HOLD, e_cause(), e_cnt());
      end
      step(4'b0, 1'b0);
    end
    cmps++;
    if (cause !== (LOG ? 4'b0001 : 4'b0) || viol_cnt !== (LOG ? 8'd1 : 8'd0)) begin
      errs++;
      $display("FAIL single_end: got cause=%h cnt=%0d", cause, viol_cnt);
    end
  endtask

  task automatic test_extended();
    do_reset();
    for (int c = 1; c <= 9; c++) step(4'b0, 1'b0);
    for (int c = 10; c <= 46; c++) begin
      step(((c <= 40) ? 4'b0001 : 4'b0) | ((c == 15) ? 4'b0100 : 4'b0), 1'b0);
      cmps++;
      if (reset_out !== (c >= 10 && c <= 40) || {busy, cause, viol_cnt} !== {m_active, e_cause(), e_cnt()}) begin
        errs++;
        $display("FAIL extended c%0d: got ro=%b busy=%b cause=%h cnt=%0d exp ro=%b cause=%h cnt=%0d",
                 c + 1, reset_out, busy, cause, viol_cnt, c >= 10 && c <= 40, e_cause(), e_cnt());
      end
    end
    cmps++;
    if (cause !== (LOG ? 4'b0101 : 4'b0) || viol_cnt !== (LOG ? 8'd1 : 8'd0)) begin
      errs++;
      $display("FAIL extended_end: got cause=%h cnt=%0d", cause, viol_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int e = 0; e < 300; e++) begin
      step(4'($urandom_range(1, 15)), 1'b0);
      for (int k = 0; k < 17; k++) begin
        cmps++;
        if ({reset_out, busy, cause, viol_cnt} !== {m_active, m_active, e_cause(), e_cnt()}) begin
          errs++;
          $display("FAIL saturation e%0d k%0d: got ro=%b cause=%h cnt=%0d exp ro=%b cause=%h cnt=%0d",
                   e, k, reset_out, cause, viol_cnt, m_active, e_cause(), e_cnt());
        end
        step(4'b0, 1'b0);
      end
    end
    cmps++;
    if (viol_cnt !== (LOG ? 8'd255 : 8'd0)) begin
      errs++;
      $display("FAIL saturation_end: got cnt=%0d exp %0d", viol_cnt, LOG ? 255 : 0);
    end
  endtask

  task automatic test_cause_clr();
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0, 1'b0);
    step(4'b0, 1'b1);
    cmps++;
    if (!reset_out || cause !== (LOG ? 4'b0010 : 4'b0) || viol_cnt !== (LOG ? 8'd1 : 8'd0)) begin
      errs++;
      $display("FAIL clr_in_assert: got ro=%b cause=%h cnt=%0d", reset_out, cause, viol_cnt);
    end
    for (int k = 0; k < 18; k++) step(4'b0, 1'b0);
    step(4'b0, 1'b1);
    cmps++;
    if (reset_out || cause !== 4'b0 || viol_cnt !== 8'd0) begin
      errs++;
      $display("FAIL clr_in_idle: got ro=%b cause=%h cnt=%0d exp 0/0/0", reset_out, cause, viol_cnt);
    end
    step(4'b1000, 1'b1);
    cmps++;
    if (!reset_out || cause !== (LOG ? 4'b1000 : 4'b0) || viol_cnt !== (LOG ? 8'd1 : 8'd0)) begin
      errs++;
      $display("FAIL clr_with_req: got ro=%b cause=%h cnt=%0d", reset_out, cause, viol_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    cmps++;
    if ({reset_out, busy, cause, viol_cnt} !== 14'd0) begin
      errs++;
      $display("FAIL async_reset: got ro=%b busy=%b cause=%h cnt=%0d exp all 0", reset_out, busy, cause, viol_cnt);
    end
    do_reset();
    step(4'b0001, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      cmps++;
      if (reset_out !== (k <= HOLD) || {cause, viol_cnt} !== {e_cause(), e_cnt()}) begin
        errs++;
        $display("FAIL after_async k%0d: got ro=%b cause=%h cnt=%0d exp ro=%b cause=%h cnt=%0d",
                 k, reset_out, cause, viol_cnt, k <= HOLD, e_cause(), e_cnt());
      end
      step(4'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(4'b0001, 1'b0);
    for (int k = 0; k < HOLD; k++) step(4'b0, 1'b0);
    cmps++;
    if (reset_out !== 1'b0) begin
      errs++;
      $display("FAIL b2b_gap: got ro=%b exp 0", reset_out);
    end
    step(4'b0010, 1'b0);
    cmps++;
    if (reset_out !== 1'b1 || cause !== (LOG ? 4'b0010 : 4'b0) || viol_cnt !== (LOG ? 8'd2 : 8'd0)) begin
      errs++;
      $display("FAIL b2b_second: got ro=%b cause=%h cnt=%0d", reset_out, cause, viol_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0, 1'($urandom_range(0, 3) == 0));
      cmps++;
      if ({reset_out, busy, cause, viol_cnt} !== {m_active, m_active, e_cause(), e_cnt()}) begin
        errs++;
        $display("FAIL random c%0d: got ro=%b busy=%b cause=%h cnt=%0d exp ro=%b cause=%h cnt=%0d",
                 c, reset_out, busy, cause, viol_cnt, m_active, e_cause(), e_cnt());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extended();
    test_saturation();
    test_cause_clr();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
